// File: rtl/bus_requester.sv
// Initiator end of the interpreter memory bus. Takes one word-wide read or
// write command from the core at a time and moves it over the byte-wide bus
// as WORD_BYTES little-endian byte transactions. Reads are guarded by a
// per-byte timeout so a dead responder still produces a (flagged) response.
module bus_requester #(
  parameter int ADDR_W     = 16,
  parameter int WORD_BYTES = 4,
  parameter int TIMEOUT    = 255
) (
  input  logic                    clk,
  input  logic                    rst,
  // core command side
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic                    cmd_we,
  input  logic [ADDR_W-1:0]       cmd_addr,
  input  logic [8*WORD_BYTES-1:0] cmd_wdata,
  output logic                    rsp_valid,
  output logic [8*WORD_BYTES-1:0] rsp_rdata,
  output logic                    rsp_err,
  // byte bus side
  output logic                    bus_req,
  output logic                    bus_we,
  output logic [ADDR_W-1:0]       bus_addr,
  output logic [7:0]              bus_wdata,
  input  logic                    bus_gnt,
  input  logic                    bus_rvalid,
  input  logic [7:0]              bus_rdata
);

  localparam int WORD_W = 8 * WORD_BYTES;
  localparam int IDX_W  = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int TMO_W  = $clog2(TIMEOUT + 1);

  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(WORD_BYTES - 1);
  localparam logic [TMO_W-1:0] TMO_LIMIT = TMO_W'(TIMEOUT);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT_RD,
    S_RESP
  } state_e;

  state_e              state_q,     state_d;
  logic [ADDR_W-1:0]   addr_q,      addr_d;
  logic                we_q,        we_d;
  logic [WORD_W-1:0]   wdata_q,     wdata_d;
  logic [IDX_W-1:0]    idx_q,       idx_d;
  logic [TMO_W-1:0]    tmo_q,       tmo_d;
  logic [WORD_W-1:0]   rbuf_q,      rbuf_d;
  logic [WORD_W-1:0]   rsp_rdata_q, rsp_rdata_d;
  logic                rsp_err_q,   rsp_err_d;

  // State and datapath registers; reset abandons any command in flight.
  always_ff @(posedge clk) begin
    // NOTE: non-blocking assignments here so every register samples the
    // pre-edge value of its neighbours, independent of statement order.
    if (rst) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      we_q        <= 1'b0;
      wdata_q     <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      rbuf_q      <= '0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      we_q        <= we_d;
      wdata_q     <= wdata_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      rbuf_q      <= rbuf_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  // Next-state logic: command capture, byte sequencing, read assembly, timeout.
  always_comb begin
    // NOTE: every _d takes its _q value first, so any path that does not
    // assign it simply holds state and no latch can be inferred.
    state_d     = state_q;
    addr_d      = addr_q;
    we_d        = we_q;
    wdata_d     = wdata_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    rbuf_d      = rbuf_q;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          addr_d    = cmd_addr;
          we_d      = cmd_we;
          wdata_d   = cmd_wdata;
          idx_d     = '0;
          tmo_d     = '0;
          rbuf_d    = '0;   // bytes never returned read back as zero
          rsp_err_d = 1'b0;
          state_d   = S_ISSUE;
        end
      end

      S_ISSUE: begin
        if (bus_gnt) begin
          if (we_q) begin
            idx_d = idx_q + 1'b1;
            if (idx_q == LAST_IDX) begin
              rsp_rdata_d = '0;
              state_d     = S_RESP;
            end
          end else begin
            tmo_d   = '0;
            state_d = S_WAIT_RD;
          end
        end
      end

      S_WAIT_RD: begin
        if (bus_rvalid) begin
          rbuf_d[{idx_q, 3'b000} +: 8] = bus_rdata;
          idx_d = idx_q + 1'b1;
          tmo_d = '0;
          if (idx_q == LAST_IDX) begin
            rsp_rdata_d = rbuf_d;
            state_d     = S_RESP;
          end else begin
            state_d = S_ISSUE;
          end
        end else begin
          tmo_d = tmo_q + 1'b1;
          if (tmo_d == TMO_LIMIT) begin
            rsp_rdata_d = rbuf_q;
            rsp_err_d   = 1'b1;
            state_d     = S_RESP;
          end
        end
      end

      S_RESP: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // Outputs are decoded from registered state only, so they are glitch-free
  // and stay put while a byte request is stalled waiting for bus_gnt.
  assign cmd_ready = (state_q == S_IDLE);
  assign rsp_valid = (state_q == S_RESP);
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;

  assign bus_req   = (state_q == S_ISSUE);
  assign bus_we    = bus_req & we_q;
  assign bus_addr  = bus_req ? (addr_q + ADDR_W'(idx_q)) : '0;
  assign bus_wdata = bus_we ? wdata_q[{idx_q, 3'b000} +: 8] : 8'h00;

endmodule

// File: tb/tb_bus_requester.sv
// Directed bench for bus_requester: the bench plays the ram responder
// (byte memory, programmable grant stall and read latency) and checks the
// byte stream, response words, error flag and cycle counts.
module tb_bus_requester;

  localparam int ADDR_W = 16;
  localparam int WB     = 4;
  localparam int TMO    = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              cmd_valid = 1'b0;
  logic              cmd_ready;
  logic              cmd_we = 1'b0;
  logic [ADDR_W-1:0] cmd_addr = '0;
  logic [8*WB-1:0]   cmd_wdata = '0;
  logic              rsp_valid;
  logic [8*WB-1:0]   rsp_rdata;
  logic              rsp_err;
  logic              bus_req;
  logic              bus_we;
  logic [ADDR_W-1:0] bus_addr;
  logic [7:0]        bus_wdata;
  logic              bus_gnt = 1'b0;
  logic              bus_rvalid = 1'b0;
  logic [7:0]        bus_rdata = 8'h00;

  always #5 clk = ~clk;

  bus_requester #(
    .ADDR_W    (ADDR_W),
    .WORD_BYTES(WB),
    .TIMEOUT   (TMO)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_we    (cmd_we),
    .cmd_addr  (cmd_addr),
    .cmd_wdata (cmd_wdata),
    .rsp_valid (rsp_valid),
    .rsp_rdata (rsp_rdata),
    .rsp_err   (rsp_err),
    .bus_req   (bus_req),
    .bus_we    (bus_we),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_gnt   (bus_gnt),
    .bus_rvalid(bus_rvalid),
    .bus_rdata (bus_rdata)
  );

  int tests_run    = 0;
  int tests_failed = 0;

  logic [7:0]  mem      [0:65535];
  logic [15:0] log_addr [0:3];
  logic [7:0]  log_data [0:3];
  int          log_cyc  [0:3];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Runs one command from an IDLE negedge to the following IDLE negedge,
  // acting as the responder. stall = idle cycles before each grant, lat =
  // cycles from grant to rvalid, bytes at index >= silent_from never answer.
  task automatic do_cmd(input logic we, input logic [15:0] addr, input logic [31:0] wd,
                        input int stall, input int lat, input int silent_from,
                        input bit rnd, input bit hold,
                        output logic [31:0] rd, output logic er, output int cyc);
    int         bytes_done = 0;
    int         stall_left;
    int         pend = 0;
    bit         done = 0;
    logic [7:0] rd_byte = 8'h00;
    logic [15:0] exp_a;

    check("cmd_ready idle", {31'b0, cmd_ready}, 32'd1);
    cmd_valid  = 1'b1;
    cmd_we     = we;
    cmd_addr   = addr;
    cmd_wdata  = wd;
    stall_left = rnd ? int'($urandom_range(0, 2)) : stall;
    rd  = 'x;
    er  = 1'bx;
    cyc = 0;

    for (int c = 1; c <= 500 && !done; c++) begin
      @(negedge clk);
      cmd_valid  = hold;
      bus_gnt    = rnd ? 1'($urandom_range(0, 1)) : 1'b0;
      bus_rvalid = 1'b0;
      bus_rdata  = 8'h00;
      if (rsp_valid === 1'b1) begin
        rd   = rsp_rdata;
        er   = rsp_err;
        cyc  = c;
        done = 1;
      end else begin
        check("cmd_ready busy", {31'b0, cmd_ready}, 32'd0);
        if (pend > 0) begin
          pend--;
          if (pend == 0) begin
            bus_rvalid = 1'b1;
            bus_rdata  = rd_byte;
          end
        end
        if (bus_req === 1'b1) begin
          exp_a = addr + 16'(bytes_done);
          check("bus_addr", {16'b0, bus_addr}, {16'b0, exp_a});
          check("bus_we", {31'b0, bus_we}, {31'b0, we});
          if (we) check("bus_wdata", {24'b0, bus_wdata}, {24'b0, wd[8*bytes_done +: 8]});
          if (stall_left > 0) begin
            stall_left--;
            bus_gnt = 1'b0;
          end else begin
            bus_gnt = 1'b1;
            if (bytes_done < 4) begin
              log_addr[bytes_done] = bus_addr;
              log_data[bytes_done] = bus_wdata;
              log_cyc[bytes_done]  = c;
            end
            if (we) begin
              mem[bus_addr] = bus_wdata;
            end else begin
              // rvalid in the grant cycle itself must be ignored
              bus_rvalid = 1'b1;
              bus_rdata  = 8'hA5;
              if (bytes_done < silent_from) begin
                pend    = rnd ? int'($urandom_range(1, 3)) : lat;
                rd_byte = mem[bus_addr];
              end
            end
            bytes_done++;
            stall_left = rnd ? int'($urandom_range(0, 2)) : stall;
          end
        end
      end
    end

    if (!done) begin
      check("rsp_valid seen", {31'b0, done}, 32'd1);
    end else begin
      @(negedge clk);
      bus_gnt    = 1'b0;
      bus_rvalid = 1'b0;
      check("rsp_valid single pulse", {31'b0, rsp_valid}, 32'd0);
      check("cmd_ready after resp", {31'b0, cmd_ready}, 32'd1);
    end
  endtask

  logic [31:0] rd;
  logic        er;
  int          cyc;
  logic [15:0] t1_addr [0:3];
  logic [7:0]  t1_data [0:3];
  logic [15:0] t3_addr [0:3];
  logic [7:0]  t3_data [0:3];
  logic [31:0] shadow  [0:3];

  initial begin
    t1_addr = '{16'h0100, 16'h0101, 16'h0102, 16'h0103};
    t1_data = '{8'hEF, 8'hBE, 8'hAD, 8'hDE};
    t3_addr = '{16'hFFFE, 16'hFFFF, 16'h0000, 16'h0001};
    t3_data = '{8'h44, 8'h33, 8'h22, 8'h11};
    for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
    for (int i = 0; i < 4; i++) shadow[i] = 32'h0;

    // Reset values
    repeat (3) @(negedge clk);
    check("rst cmd_ready", {31'b0, cmd_ready}, 32'd1);
    check("rst rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("rst rsp_err",   {31'b0, rsp_err},   32'd0);
    check("rst rsp_rdata", rsp_rdata,          32'h0);
    check("rst bus_req",   {31'b0, bus_req},   32'd0);
    check("rst bus_we",    {31'b0, bus_we},    32'd0);
    check("rst bus_addr",  {16'b0, bus_addr},  32'h0);
    check("rst bus_wdata", {24'b0, bus_wdata}, 32'h0);
    rst = 1'b0;
    @(negedge clk);

    // 1: write DEADBEEF @0100, grant always
    do_cmd(1'b1, 16'h0100, 32'hDEADBEEF, 0, 1, 4, 1'b0, 1'b0, rd, er, cyc);
    for (int k = 0; k < 4; k++) begin
      check("t1 addr", {16'b0, log_addr[k]}, {16'b0, t1_addr[k]});
      check("t1 data", {24'b0, log_data[k]}, {24'b0, t1_data[k]});
      check("t1 byte cycle", log_cyc[k], k + 1);
    end
    check("t1 latency", cyc, 32'd5);
    check("t1 rsp_err", {31'b0, er}, 32'd0);
    check("t1 rsp_rdata", rd, 32'h0);

    // 2: read back, 1-cycle grant stall, latency 2
    do_cmd(1'b0, 16'h0100, 32'h0, 1, 2, 4, 1'b0, 1'b0, rd, er, cyc);
    check("t2 rsp_rdata", rd, 32'hDEADBEEF);
    check("t2 rsp_err", {31'b0, er}, 32'd0);
    check("t2 latency", cyc, 32'd17);

    // 3: write across the address wrap
    do_cmd(1'b1, 16'hFFFE, 32'h11223344, 0, 1, 4, 1'b0, 1'b0, rd, er, cyc);
    for (int k = 0; k < 4; k++) begin
      check("t3 addr", {16'b0, log_addr[k]}, {16'b0, t3_addr[k]});
      check("t3 data", {24'b0, log_data[k]}, {24'b0, t3_data[k]});
    end
    check("t3 latency", cyc, 32'd5);

    // 4: responder goes silent after the first byte -> timeout
    do_cmd(1'b0, 16'h0100, 32'h0, 0, 1, 1, 1'b0, 1'b0, rd, er, cyc);
    check("t4 rsp_err", {31'b0, er}, 32'd1);
    check("t4 rsp_rdata", rd, 32'h000000EF);
    check("t4 latency", cyc, 32'd12);
    @(negedge clk);
    check("t4 err held", {31'b0, rsp_err}, 32'd1);
    check("t4 rdata held", rsp_rdata, 32'h000000EF);
    do_cmd(1'b1, 16'h0500, 32'h55667788, 0, 1, 4, 1'b0, 1'b0, rd, er, cyc);
    check("t4 err cleared", {31'b0, er}, 32'd0);

    // 5: reset while byte 2 of a write is on the bus
    cmd_valid = 1'b1;
    cmd_we    = 1'b1;
    cmd_addr  = 16'h0200;
    cmd_wdata = 32'hCAFEF00D;
    bus_gnt   = 1'b1;
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("t5 byte2 addr", {16'b0, bus_addr}, 32'h0202);
    bus_gnt = 1'b0;
    rst     = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("t5 bus_req", {31'b0, bus_req}, 32'd0);
    check("t5 cmd_ready", {31'b0, cmd_ready}, 32'd1);
    for (int i = 0; i < 6; i++) begin
      check("t5 no rsp_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
    end
    do_cmd(1'b0, 16'h0100, 32'h0, 0, 1, 4, 1'b0, 1'b0, rd, er, cyc);
    check("t5 read rdata", rd, 32'hDEADBEEF);
    check("t5 read err", {31'b0, er}, 32'd0);
    check("t5 read latency", cyc, 32'd9);

    // 6: back-to-back random commands, cmd_valid held high
    for (int n = 0; n < 100; n++) begin
      logic        we;
      int          k;
      logic [31:0] wd;
      we = 1'($urandom_range(0, 1));
      k  = int'($urandom_range(0, 3));
      wd = $urandom;
      do_cmd(we, 16'h0400 + 16'(4 * k), wd, 0, 1, 4, 1'b1, 1'b1, rd, er, cyc);
      if (we) begin
        shadow[k] = wd;
        check("t6 write rdata", rd, 32'h0);
      end else begin
        check("t6 read rdata", rd, shadow[k]);
      end
      check("t6 rsp_err", {31'b0, er}, 32'd0);
    end
    cmd_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
